// File: rtl/ln_pkg.sv
// Shared definitions for the LN parameter loader: FSM encoding and the
// derived geometry (pairs per word, words per group, group byte stride).
package ln_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RECV = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } ln_state_e;

  // Weight/bias pairs carried by one read-data word.
  function automatic int calc_npw(input int axi_dw, input int bn_dw);
    return axi_dw / (2 * bn_dw);
  endfunction

  // Read-data words needed to fill one TOUT-channel group.
  function automatic int calc_wpg(input int tout, input int npw);
    return tout / npw;
  endfunction

  // Byte distance between consecutive groups in memory.
  function automatic int calc_stride(input int tout, input int bn_dw);
    return (tout * bn_dw * 2) / 8;
  endfunction

  // Bit offset of the weight half of pair k (low half of the pair).
  function automatic int pair_wt_off(input int k, input int bn_dw);
    return 2 * bn_dw * k;
  endfunction

  // Bit offset of the bias half of pair k (high half of the pair).
  function automatic int pair_bias_off(input int k, input int bn_dw);
    return 2 * bn_dw * k + bn_dw;
  endfunction

endpackage

// File: rtl/ln_pair_unpack.sv
// Combinational split of one read-data word into NPW weight lanes and
// NPW bias lanes. Lane k of each output comes from pair k of the word.
module ln_pair_unpack
  import ln_pkg::*;
#(
  parameter int AXI_DW = 256,
  parameter int BN_DW  = 16
) (
  input  logic [AXI_DW-1:0]   word,
  output logic [AXI_DW/2-1:0] wt,
  output logic [AXI_DW/2-1:0] bias
);

  localparam int NPW = calc_npw(AXI_DW, BN_DW);

  for (genvar gi = 0; gi < NPW; gi++) begin : g_pair
    localparam int WO = pair_wt_off(gi, BN_DW);
    localparam int BO = pair_bias_off(gi, BN_DW);
    assign wt[gi*BN_DW +: BN_DW]   = word[WO +: BN_DW];
    assign bias[gi*BN_DW +: BN_DW] = word[BO +: BN_DW];
  end

endmodule

// File: rtl/ln_param_loader.sv
// Fetches LayerNorm weight/bias parameters group by group: one burst read
// per TOUT-channel group, assembles the words into staging registers and
// presents the whole group on a valid/ready output. Only one group is in
// flight at a time, so the staging registers double as the output.
module ln_param_loader
  import ln_pkg::*;
#(
  parameter int AXI_DW = 256,
  parameter int BN_DW  = 16,
  parameter int TOUT   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           ch_padded,
  input  logic [ADDR_W-1:0]     base_addr,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_W-1:0]     rd_req_addr,
  output logic [7:0]            rd_req_len,
  input  logic                  rd_dat_valid,
  output logic                  rd_dat_ready,
  input  logic [AXI_DW-1:0]     rd_dat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TOUT*BN_DW-1:0] out_wt,
  output logic [TOUT*BN_DW-1:0] out_bias,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int NPW    = calc_npw(AXI_DW, BN_DW);
  localparam int WPG    = calc_wpg(TOUT, NPW);
  localparam int STRIDE = calc_stride(TOUT, BN_DW);
  localparam int WCW    = (WPG > 1) ? $clog2(WPG) : 1;
  localparam int LANE_W = AXI_DW / 2;
  localparam logic [WCW-1:0] W_LAST = WCW'(WPG - 1);

  ln_state_e state, state_next;

  logic [ADDR_W-1:0]     addr_reg;
  logic [15:0]           g_reg;
  logic [15:0]           last_g_reg;
  logic [WCW-1:0]        w_reg;
  logic [TOUT*BN_DW-1:0] wt_reg;
  logic [TOUT*BN_DW-1:0] bias_reg;
  logic [LANE_W-1:0]     word_wt;
  logic [LANE_W-1:0]     word_bias;
  logic [15:0]           groups;
  logic                  word_acc;
  logic                  out_acc;
  logic                  is_last_group;

  assign groups        = ch_padded / 16'(TOUT);
  assign word_acc      = (state == ST_RECV) && rd_dat_valid;
  assign out_acc       = (state == ST_OUT) && out_ready;
  assign is_last_group = (g_reg == last_g_reg);

  ln_pair_unpack #(
    .AXI_DW (AXI_DW),
    .BN_DW  (BN_DW)
  ) u_unpack (
    .word (rd_dat),
    .wt   (word_wt),
    .bias (word_bias)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = (ch_padded != 16'd0) ? ST_REQ : ST_DONE;
      ST_REQ:  if (rd_req_ready) state_next = ST_RECV;
      ST_RECV: if (rd_dat_valid && (w_reg == W_LAST)) state_next = ST_OUT;
      ST_OUT:  if (out_ready) state_next = is_last_group ? ST_DONE : ST_REQ;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    rd_req_valid = 1'b0;
    rd_dat_ready = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      ST_IDLE: busy = 1'b0;
      ST_REQ:  rd_req_valid = 1'b1;
      ST_RECV: rd_dat_ready = 1'b1;
      ST_OUT: begin
        out_valid = 1'b1;
        out_last  = is_last_group;
      end
      ST_DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Group/word counters and the latched request address. The address is
  // advanced only on the out handshake so it stays put while REQ waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg   <= '0;
      g_reg      <= '0;
      last_g_reg <= '0;
      w_reg      <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        addr_reg   <= base_addr;
        g_reg      <= '0;
        last_g_reg <= groups - 16'd1;
        w_reg      <= '0;
      end
      if (word_acc) begin
        w_reg <= (w_reg == W_LAST) ? '0 : w_reg + WCW'(1);
      end
      if (out_acc && !is_last_group) begin
        g_reg    <= g_reg + 16'd1;
        addr_reg <= addr_reg + ADDR_W'(STRIDE);
      end
    end
  end

  // Staging registers: word w lands in lanes [w*NPW +: NPW].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt_reg   <= '0;
      bias_reg <= '0;
    end else if (word_acc) begin
      for (int i = 0; i < WPG; i++) begin
        if (w_reg == WCW'(i)) begin
          wt_reg[i*LANE_W +: LANE_W]   <= word_wt;
          bias_reg[i*LANE_W +: LANE_W] <= word_bias;
        end
      end
    end
  end

  assign rd_req_addr = addr_reg;
  assign rd_req_len  = 8'(WPG - 1);
  assign out_wt      = wt_reg;
  assign out_bias    = bias_reg;

endmodule

// File: tb/tb_ln_param_loader.sv
// Directed bench for ln_param_loader: table of transfer scenarios plus
// hand-written sequences for zero channels and mid-transfer reset.
module tb_ln_param_loader;

  localparam int AXI_DW = 256;
  localparam int BN_DW  = 16;
  localparam int TOUT   = 32;
  localparam int ADDR_W = 32;
  localparam int WPG    = 4;
  localparam int STRIDE = 128;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [15:0]           ch_padded;
  logic [ADDR_W-1:0]     base_addr;
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_W-1:0]     rd_req_addr;
  logic [7:0]            rd_req_len;
  logic                  rd_dat_valid;
  logic                  rd_dat_ready;
  logic [AXI_DW-1:0]     rd_dat;
  logic                  out_valid;
  logic                  out_ready;
  logic [TOUT*BN_DW-1:0] out_wt;
  logic [TOUT*BN_DW-1:0] out_bias;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  ln_param_loader #(
    .AXI_DW (AXI_DW),
    .BN_DW  (BN_DW),
    .TOUT   (TOUT),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ch_padded    (ch_padded),
    .base_addr    (base_addr),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_req_len   (rd_req_len),
    .rd_dat_valid (rd_dat_valid),
    .rd_dat_ready (rd_dat_ready),
    .rd_dat       (rd_dat),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_wt       (out_wt),
    .out_bias     (out_bias),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int req_hs = 0;
  int req_valid_cycles = 0;
  int done_cnt = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_req_valid) req_valid_cycles <= req_valid_cycles + 1;
    if (rd_req_valid && rd_req_ready) req_hs <= req_hs + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Word w of group g: pair k carries weight g*4096 + 16*(w*8+k), bias = ~weight.
  function automatic logic [AXI_DW-1:0] mk_word(input int g, input int w);
    logic [AXI_DW-1:0] r;
    logic [15:0] wt;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      wt = 16'(g * 4096 + 16 * (w * 8 + k));
      r[32*k +: 16]    = wt;
      r[32*k+16 +: 16] = ~wt;
    end
    return r;
  endfunction

  function automatic logic [511:0] exp_wt(input int g);
    logic [511:0] r;
    for (int i = 0; i < 32; i++) r[16*i +: 16] = 16'(g * 4096 + 16 * i);
    return r;
  endfunction

  function automatic logic [511:0] exp_bias(input int g);
    logic [511:0] r;
    for (int i = 0; i < 32; i++) r[16*i +: 16] = ~(16'(g * 4096 + 16 * i));
    return r;
  endfunction

  typedef struct {
    int          ch;
    logic [31:0] base;
    int          req_delay;
    int          gap;
    int          out_hold;
    int          exp_groups;
  } vec_t;

  task automatic run_transfer(input vec_t v, input string tag);
    int req0, done0, t0, t_hs, waited;
    logic [31:0] exp_addr;
    req0  = req_hs;
    done0 = done_cnt;
    t_hs  = 0;
    @(negedge clk);
    start = 1'b1; ch_padded = 16'(v.ch); base_addr = v.base; t0 = cyc;
    @(negedge clk);
    start = 1'b0; ch_padded = 16'hFFE0; base_addr = 32'hDEAD_BEE0;
    for (int g = 0; g < v.exp_groups; g++) begin
      waited = 0;
      while (!rd_req_valid && waited < 20) begin @(negedge clk); waited++; end
      chk({tag, "_req_valid"}, 512'(rd_req_valid), 512'(1));
      if (!rd_req_valid) return;
      exp_addr = v.base + 32'(g * STRIDE);
      chk({tag, "_req_addr"}, 512'(rd_req_addr), 512'(exp_addr));
      chk({tag, "_req_len"}, 512'(rd_req_len), 512'(WPG - 1));
      repeat (v.req_delay) begin
        @(negedge clk);
        chk({tag, "_req_hold_valid"}, 512'(rd_req_valid), 512'(1));
        chk({tag, "_req_hold_addr"}, 512'({rd_req_len, rd_req_addr}), 512'({8'(WPG - 1), exp_addr}));
      end
      rd_req_ready = 1'b1;
      @(negedge clk);
      rd_req_ready = 1'b0;
      for (int w = 0; w < WPG; w++) begin
        repeat (v.gap) begin
          rd_dat_valid = 1'b0; rd_dat = {8{$urandom()}};
          @(negedge clk);
        end
        rd_dat_valid = 1'b1; rd_dat = mk_word(g, w);
        chk({tag, "_dat_ready"}, 512'(rd_dat_ready), 512'(1));
        @(negedge clk);
      end
      // Offer a stray beat while in OUT: it must not be consumed.
      rd_dat_valid = 1'b1; rd_dat = {8{$urandom()}};
      if (v.req_delay == 0 && v.gap == 0)
        chk({tag, "_latency"}, 512'(cyc - ((g == 0) ? t0 : t_hs)), 512'(WPG + 2));
      chk({tag, "_out_valid"}, 512'(out_valid), 512'(1));
      chk({tag, "_dat_ready_out"}, 512'(rd_dat_ready), 512'(0));
      chk({tag, "_out_wt"}, out_wt, exp_wt(g));
      chk({tag, "_out_bias"}, out_bias, exp_bias(g));
      chk({tag, "_out_last"}, 512'(out_last), 512'(g == v.exp_groups - 1));
      repeat (v.out_hold) begin
        @(negedge clk);
        rd_dat = {8{$urandom()}};
        chk({tag, "_hold_valid"}, 512'({out_valid, rd_req_valid}), 512'(2'b10));
        chk({tag, "_hold_wt"}, out_wt, exp_wt(g));
        chk({tag, "_hold_bias"}, out_bias, exp_bias(g));
      end
      out_ready = 1'b1; t_hs = cyc;
      @(negedge clk);
      out_ready = 1'b0; rd_dat_valid = 1'b0;
    end
    waited = 0;
    while (done_cnt == done0 && waited < 10) begin @(negedge clk); waited++; end
    repeat (3) @(negedge clk);
    chk({tag, "_done_count"}, 512'(done_cnt - done0), 512'(1));
    chk({tag, "_req_count"}, 512'(req_hs - req0), 512'(v.exp_groups));
    chk({tag, "_idle"}, 512'(busy), 512'(0));
    $display("transfer %s ch=%0d groups=%0d checks=%0d failures=%0d", tag, v.ch, v.exp_groups, checks, failures);
  endtask

  vec_t vecs[5];

  initial begin
    int done0, req0, rv0, t0, waited;
    vecs[0] = '{64,  32'h0100_0000, 0, 0, 0,  2};
    vecs[1] = '{96,  32'h0000_1000, 0, 0, 0,  3};
    vecs[2] = '{64,  32'h0100_0000, 0, 0, 10, 2};
    vecs[3] = '{32,  32'h2000_0040, 5, 1, 0,  1};
    vecs[4] = '{128, 32'h0000_0000, 2, 2, 3,  4};

    rst_n = 1'b0; start = 1'b0; ch_padded = '0; base_addr = '0;
    rd_req_ready = 1'b0; rd_dat_valid = 1'b0; rd_dat = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 512'({rd_req_valid, rd_dat_ready, out_valid, out_last, busy, done}), 512'(0));
    chk("reset_stage", {out_wt, out_bias} != '0 ? 512'(1) : 512'(0), 512'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_transfer(vecs[i], $sformatf("vec%0d", i));

    // Zero channels: done without any read request.
    done0 = done_cnt; rv0 = req_valid_cycles;
    @(negedge clk);
    start = 1'b1; ch_padded = 16'd0; base_addr = 32'h0100_0000; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (done_cnt == done0 && waited < 10) begin @(negedge clk); waited++; end
    chk("zero_done_latency", 512'(cyc - t0), 512'(2));
    repeat (3) @(negedge clk);
    chk("zero_done_count", 512'(done_cnt - done0), 512'(1));
    chk("zero_req_cycles", 512'(req_valid_cycles - rv0), 512'(0));
    $display("transfer zero ch=0 checks=%0d failures=%0d", checks, failures);

    // Reset in the middle of RECV.
    req0 = req_hs;
    @(negedge clk);
    start = 1'b1; ch_padded = 16'd64; base_addr = 32'h0100_0000;
    @(negedge clk);
    start = 1'b0; rd_req_ready = 1'b1;
    @(negedge clk);
    rd_req_ready = 1'b0; rd_dat_valid = 1'b1; rd_dat = mk_word(0, 0);
    @(negedge clk);
    rd_dat = mk_word(0, 1);
    @(negedge clk);
    rd_dat_valid = 1'b0;
    chk("rst_in_recv", 512'(rd_dat_ready), 512'(1));
    chk("rst_req_count", 512'(req_hs - req0), 512'(1));
    done0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl", 512'({rd_req_valid, rd_dat_ready, out_valid, out_last, busy, done}), 512'(0));
    chk("rst_addr", 512'(rd_req_addr), 512'(0));
    chk("rst_wt", out_wt, 512'(0));
    chk("rst_bias", out_bias, 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_no_done", 512'(done_cnt - done0), 512'(0));
    chk("rst_idle", 512'({busy, rd_req_valid}), 512'(0));
    $display("transfer reset_mid_recv checks=%0d failures=%0d", checks, failures);
    run_transfer('{32, 32'h0300_0000, 0, 0, 0, 1}, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
